// File: rtl/regfile_pkg.sv
// Register-file geometry and types shared by the writeback arbiter, register file and issue stage.
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 2 ** REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the pointer, with wrap.
// Latency: grant is combinational; the pointer moves one cycle after an accepted grant.
// Backpressure: the caller drops req to withhold grants; the pointer only moves when advance=1.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources, round-robin.
// Latency: one cycle from accepted request to out_write_enable; one write per cycle.
// Backpressure: in_hold or a competing grant keeps req_ready low; sources hold their request.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int XLEN       = regfile_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_number,
    input  logic [NUM_REQ*XLEN-1:0]       req_value,
    input  logic                          in_hold,
    output logic                          out_write_enable,
    output logic [REG_ADDR_W-1:0]         out_write_number,
    output logic [XLEN-1:0]               out_write_value,
    output logic [2**REG_ADDR_W-1:0]      pending_mask
);
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    grant;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_num;
    logic [XLEN-1:0]       sel_val;

    // Hold and reset mask the requests, so grant equals ready and implies valid.
    assign arb_req   = (in_hold || rst) ? '0 : req_valid;
    assign req_ready = grant;
    assign xfer      = |grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (xfer),
        .grant   (grant)
    );

    always_comb begin
        sel_num = '0;
        sel_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_num = sel_num | req_number[i*REG_ADDR_W +: REG_ADDR_W];
                sel_val = sel_val | req_value[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_write_enable <= 1'b0;
            out_write_number <= '0;
            out_write_value  <= '0;
        end else begin
            out_write_enable <= xfer && (sel_num != '0);
            if (xfer) begin
                out_write_number <= sel_num;
                out_write_value  <= sel_val;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) pending_mask[req_number[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
        end
        if (out_write_enable) pending_mask[out_write_number] = 1'b1;
        pending_mask[0] = 1'b0;
    end
endmodule
